// File: rtl/vga_scan_out.sv
// Raster timing master and latency-aligned VGA pixel output stage.
// Also snapshots the displayed variables once per frame during vertical blank.
module vga_scan_out #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  color_px,
    input  logic        hold,
    input  logic [15:0] var_in1,
    input  logic [15:0] var_in2,
    input  logic [15:0] var_in3,
    input  logic [15:0] var_in4,
    output logic [9:0]  x_px,
    output logic [9:0]  y_px,
    output logic [15:0] var1,
    output logic [15:0] var2,
    output logic [15:0] var3,
    output logic [15:0] var4,
    output logic        frame_tick,
    output logic        hsync,
    output logic        vsync,
    output logic [5:0]  rgb
);

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } scan_flags_t;

    scan_flags_t flags_raw;
    scan_flags_t flags_d;
    logic        snap;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_px <= '0;
            y_px <= '0;
        end else if (x_px == H_LAST) begin
            x_px <= '0;
            y_px <= (y_px == V_LAST) ? 10'd0 : y_px + 10'd1;
        end else begin
            x_px <= x_px + 10'd1;
        end
    end

    always_comb begin
        flags_raw     = '0;
        flags_raw.act = (x_px < H_ACT) && (y_px < V_ACT);
        flags_raw.hs  = (x_px >= HS_FIRST) && (x_px <= HS_LAST);
        flags_raw.vs  = (y_px >= VS_FIRST) && (y_px <= VS_LAST);
    end

    // Delay the flags so they line up with color_px coming back from the overlays.
    generate
        if (PIPE_LAT == 0) begin : g_no_delay
            assign flags_d = flags_raw;
        end else begin : g_delay
            scan_flags_t stage [PIPE_LAT];

            // NOTE: the delay line is reset (it is only a few flops) so the first
            // PIPE_LAT pixels after reset come out blank with inactive sync.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= flags_raw;
                    for (int i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
                end
            end

            assign flags_d = stage[PIPE_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb   <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else begin
            rgb   <= flags_d.act ? color_px : 6'd0;
            hsync <= flags_d.hs ? SYNC_POL : ~SYNC_POL;
            vsync <= flags_d.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Start of the first blank line: the whole visible frame has been scanned.
    assign snap       = (x_px == 10'd0) && (y_px == V_ACT);
    assign frame_tick = snap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            var1 <= '0;
            var2 <= '0;
            var3 <= '0;
            var4 <= '0;
        end else if (snap && !hold) begin
            var1 <= var_in1;
            var2 <= var_in2;
            var3 <= var_in3;
            var4 <= var_in4;
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out on a reduced raster so whole frames run quickly.
module tb_vga_scan_out;

    localparam int   HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int   VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FRAME = HT * VT;
    localparam int   LAT = 2;
    localparam logic POL = 1'b0;

    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic [9:0] x;
    } coord_t;

    typedef struct packed {
        logic [5:0] rgb;
        logic       hsync;
        logic       vsync;
    } pin_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  color_px;
    logic        hold;
    logic [15:0] var_in1, var_in2, var_in3, var_in4;
    logic [9:0]  x_px, y_px;
    logic [15:0] var1, var2, var3, var4;
    logic        frame_tick, hsync, vsync;
    logic [5:0]  rgb;

    int          vectors;
    int          miscompares;
    int          mode;
    int          mx, my;
    logic [15:0] mvar [4];
    coord_t      hist [$];
    pin_t        sb [$];

    always #5 clk = ~clk;

    vga_scan_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .PIPE_LAT(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .color_px(color_px), .hold(hold),
        .var_in1(var_in1), .var_in2(var_in2), .var_in3(var_in3), .var_in4(var_in4),
        .x_px(x_px), .y_px(y_px),
        .var1(var1), .var2(var2), .var3(var3), .var4(var4),
        .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d)", tag, got, exp, mx, my);
        end
    endtask

    function automatic coord_t model_flags(input int x, input int y);
        coord_t c;
        c.act = (x < HA) && (y < VA);
        c.hs  = (x >= HA + HF) && (x < HA + HF + HS);
        c.vs  = (y >= VA + VF) && (y < VA + VF + VS);
        c.x   = 10'(x);
        return c;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_x"}, 32'(x_px), 0);
        check({tag, "_y"}, 32'(y_px), 0);
        check({tag, "_rgb"}, 32'(rgb), 0);
        check({tag, "_hsync"}, 32'(hsync), 1);
        check({tag, "_vsync"}, 32'(vsync), 1);
        check({tag, "_tick"}, 32'(frame_tick), 0);
        check({tag, "_vars"}, {var1, var2} | {var3, var4}, 0);
    endtask

    task automatic model_reset();
        pin_t p;
        mx = 0;
        my = 0;
        for (int i = 0; i < 4; i++) mvar[i] = '0;
        sb.delete();
        hist.delete();
        p.rgb   = '0;
        p.hsync = ~POL;
        p.vsync = ~POL;
        sb.push_back(p);
        for (int i = 0; i < LAT; i++) hist.push_back('0);
    endtask

    // One clock: compare the DUT against the model, drive color for the pixel whose
    // flags reach the output stage now, push its expected pins, advance the model.
    task automatic cycle();
        pin_t       p;
        coord_t     c;
        logic       tick_exp;
        logic [5:0] col;
        tick_exp = (mx == 0) && (my == VA);
        check("x_px", 32'(x_px), 32'(mx));
        check("y_px", 32'(y_px), 32'(my));
        check("frame_tick", 32'(frame_tick), 32'(tick_exp));
        if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 1);
        end else begin
            p = sb.pop_front();
            check("rgb", 32'(rgb), 32'(p.rgb));
            check("hsync", 32'(hsync), 32'(p.hsync));
            check("vsync", 32'(vsync), 32'(p.vsync));
        end
        check("var1", 32'(var1), 32'(mvar[0]));
        check("var2", 32'(var2), 32'(mvar[1]));
        check("var3", 32'(var3), 32'(mvar[2]));
        check("var4", 32'(var4), 32'(mvar[3]));

        hist.push_back(model_flags(mx, my));
        c = hist.pop_front();
        case (mode)
            0:       col = 6'b110000;
            1:       col = c.act ? ((c.x == 10'd0) ? 6'b111111 : 6'b000000) : 6'($urandom);
            default: col = 6'($urandom);
        endcase
        color_px = col;
        p.rgb    = c.act ? col : 6'd0;
        p.hsync  = c.hs ? POL : ~POL;
        p.vsync  = c.vs ? POL : ~POL;
        sb.push_back(p);

        if (tick_exp && !hold) begin
            mvar[0] = var_in1;
            mvar[1] = var_in2;
            mvar[2] = var_in3;
            mvar[3] = var_in4;
        end
        if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic run_to_tick();
        int n;
        n = 0;
        while (!(mx == 0 && my == VA) && n < 2 * FRAME) begin
            cycle();
            n++;
        end
        check("tick_reached", 32'(frame_tick), 1);
    endtask

    initial begin
        int t;
        vectors     = 0;
        miscompares = 0;
        mode        = 1;
        reset_n     = 1'b0;
        hold        = 1'b0;
        color_px    = 6'd0;
        var_in1     = 16'h1234;
        var_in2     = 16'h5678;
        var_in3     = 16'h9abc;
        var_in4     = 16'hdef0;
        mx          = 0;
        my          = 0;

        repeat (5) begin
            @(negedge clk);
            #1;
            color_px = 6'($urandom);
            check_reset("rst");
        end

        reset_n = 1'b1;
        model_reset();

        // First snapshot takes var_in1 = 1234 with hold low.
        run_to_tick();
        cycle();
        check("snap_var1", 32'(var1), 32'h1234);

        // A mid-frame change of the live value must not reach the display.
        var_in1 = 16'hbeef;
        var_in2 = 16'h0f0f;
        mode    = 0;
        repeat (HT * 5) cycle();
        check("var1_stable", 32'(var1), 32'h1234);

        // hold skips the snapshot but the tick still pulses.
        hold = 1'b1;
        run_to_tick();
        cycle();
        check("hold_var1", 32'(var1), 32'h1234);
        hold = 1'b0;

        mode = 2;
        run_to_tick();
        cycle();
        check("resnap_var1", 32'(var1), 32'hbeef);
        check("resnap_var2", 32'(var2), 32'h0f0f);

        // Mid-frame reset, then time the first tick after release.
        mode = 0;
        t = 0;
        while (!(my == 5 && mx == 7) && t < 2 * FRAME) begin
            cycle();
            t++;
        end
        reset_n = 1'b0;
        #1;
        check_reset("mid_rst");
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset("mid_rst_hold");
        end
        reset_n = 1'b1;
        model_reset();
        mode = 1;
        t = 0;
        while (frame_tick !== 1'b1 && t < 2 * FRAME) begin
            cycle();
            t++;
        end
        check("first_tick_delay", 32'(t), 32'(VA * HT));
        repeat (HT + 3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
- Raster timing master and pixel output stage for the scope display.
- Generates the x_px/y_px scan coordinates consumed by the overlay and renderer blocks (e.g. the hex number overlay).
- Accepts their 6-bit color_px back after a fixed pipeline latency, re-aligns sync/blank to that latency and drives the VGA pins.
- Snapshots the four displayed 16-bit variables once per frame, during vertical blank, so on-screen values never tear mid-frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
PIPE_LAT, 2, clocks from x_px/y_px to the matching color_px; legal 0..7

Ports:
clk  in  1  pixel clock (25 MHz for defaults)
reset_n  in  1  asynchronous active-low reset
color_px  in  6  pixel colour from overlay chain, {r[1:0],g[1:0],b[1:0]}
hold  in  1  1 = skip this frame's variable snapshot
var_in1..var_in4  in  16 each  live variable values
x_px  out  10  current horizontal count
y_px  out  10  current vertical count
var1..var4  out  16 each  frame-stable snapshots fed to the overlays
frame_tick  out  1  one-clock pulse on each snapshot opportunity
hsync  out  1  horizontal sync, latency-aligned
vsync  out  1  vertical sync, latency-aligned
rgb  out  6  pixel to DAC; 0 during blanking

Behaviour:
- Reset (async assert, sync release): x_px=0, y_px=0, rgb=0, hsync=vsync=~SYNC_POL, frame_tick=0, var1..var4=0, all delay-line stages cleared to the blank/inactive-sync state.
- Counters:
  - H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - x_px increments every clock and wraps H_TOT-1 -> 0.
  - On that wrap y_px increments, wrapping V_TOT-1 -> 0.
  - Both are registered; x_px/y_px keep counting through blanking (max 799/524). Overlays bound-check themselves.
- Raw per-cycle flags from the counters:
  - act = (x_px<H_ACTIVE)&&(y_px<V_ACTIVE)
  - hs = x_px in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs = y_px in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- Alignment:
  - act/hs/vs pass through a PIPE_LAT-stage shift register (PIPE_LAT=0: no stages).
  - Output register at clock edge t+1:
    - rgb = act_d(t) ? color_px(t) : 0
    - hsync = hs_d(t) ? SYNC_POL : ~SYNC_POL
    - vsync likewise
  - Net effect: the pin-level rgb/sync for counter value (x,y) appear PIPE_LAT+1 clocks after x_px=x, y_px=y. color_px is never sampled for blanked pixels.
- Snapshot:
  - Condition: x_px==0 && y_px==V_ACTIVE (start of first blank line).
  - frame_tick=1 for exactly that one cycle, independent of hold.
  - In the same cycle, if hold==0, var1..var4 <= var_in1..var_in4; if hold==1, var outputs keep their old value.
  - var outputs change at no other time.
- hold has no effect on timing, sync or rgb.
- reset_n asserted mid-frame: all outputs return to reset values immediately.
  - After release the frame restarts at (0,0).
  - The first frame_tick comes V_ACTIVE*H_TOT clocks after release, the cycle x_px==0, y_px==V_ACTIVE is first presented (384000 for defaults).
- Arithmetic: 10-bit unsigned counters; compare constants are sized to 10 bits. Parameter sums must fit 10 bits (H_TOT, V_TOT ≤ 1023).

Test Plan:
- Reset: hold reset_n=0 for 5 clocks, release -> all outputs at reset values during reset; x_px counts 0,1,2... from the first clock after release; rgb=0, hsync=vsync=1.
- Line/frame timing (defaults): hsync low for exactly 96 clocks per 800-clock line. The first hsync low edge comes 659 clocks after x_px=0 (656+PIPE_LAT+1). vsync low for 1600 clocks per 420000-clock frame. frame_tick period is 420000 clocks.
- Latency alignment, PIPE_LAT=2: drive color_px=6'b111111 only when the x_px value seen 2 clocks earlier was 0 -> rgb=6'b111111 for exactly one clock per visible line, 3 clocks after x_px=0; rgb=0 on all lines with y_px≥480.
- Blank gating: drive color_px=6'b110000 constantly -> rgb=6'b110000 exactly for 640 consecutive clocks per visible line and 0 otherwise; 307200 non-zero clocks per frame.
- Snapshot and hold: var_in1=16'h1234, hold=0 at the tick -> var1=16'h1234 from the next clock. Change var_in1 mid-frame to 16'hBEEF -> var1 stays 16'h1234 until the next tick. hold=1 at that tick -> var1 still 16'h1234 while frame_tick still pulses.
- Mid-frame reset: assert reset_n at y_px=200 -> outputs go to reset values immediately. After release, the first frame_tick occurs after exactly 384000 clocks.
